// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
package instr_feeder_pkg;

   localparam int unsigned WORD_W = 16;

   localparam logic [2:0] PHASE_IDLE = 3'd0;
   localparam logic [2:0] PHASE_LAST = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_STOP  = 3'd4,
      ST_DONE  = 3'd5
   } feeder_state_t;

   // One word offered by the host on the load port.
   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } ld_word_t;

endpackage

// File: rtl/instr_feeder_buf.sv
// Simple dual-port instruction RAM: synchronous write, synchronous read.
// The read register doubles as the instruction output, so it has a clear.
module instr_buf
   import instr_feeder_pkg::*;
#(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic              i_rd_clr,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [WORD_W-1:0] o_rd_data
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rd_data;

   // Write port.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read port register; clear has priority over a read.
   always_ff @(posedge i_clk) begin
      if (i_rd_clr) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_feeder.sv
// Host-side instruction source for the phase-sequenced core.
// Loads a program into a buffer, then feeds it to the core on phase 5 edges,
// bracketing the run with single-cycle exec pulses.
// Optional feature: define INSTR_FEEDER_LOOP_EN to replay the program
// continuously until a start request in RUN stops it.
module instr_feeder
   import instr_feeder_pkg::*;
#(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ld_valid,
   output logic              o_ld_ready,
   input  logic [WORD_W-1:0] i_ld_data,
   input  logic              i_ld_last,
   input  logic              i_start,
   input  logic [2:0]        i_phase,
   output logic [WORD_W-1:0] o_meirei,
   output logic              o_exec,
   output logic              o_busy,
   output logic              o_done,
   output logic [AW:0]       o_prog_len
);

   feeder_state_t r_state, w_state_nxt;
   logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
   logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic [AW:0]   r_prog_len, w_prog_len_nxt;
   logic          r_exec, w_exec_nxt;
   logic          r_busy;
   logic          r_done;

   logic          w_ld_ready;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic          w_rd_en;
   logic          w_rd_clr;
   logic [AW-1:0] w_rd_addr;
   logic          w_phase_last;
   logic          w_last_word;
   ld_word_t      w_ld_word;

   assign w_ld_word    = '{last: i_ld_last, data: i_ld_data};
   assign w_phase_last = (i_phase == PHASE_LAST);
   // rd_ptr points one past the word being handed over; prog_len==DEPTH wraps to 0.
   assign w_last_word  = (r_rd_ptr == r_prog_len[AW-1:0]);

   // Next-state, buffer control and pulse generation.
   always_comb begin
      w_state_nxt    = r_state;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_prog_len_nxt = r_prog_len;
      w_exec_nxt     = 1'b0;
      w_ld_ready     = 1'b0;
      w_wr_en        = 1'b0;
      w_wr_addr      = r_wr_ptr;
      w_rd_en        = 1'b0;
      w_rd_clr       = i_rst;
      w_rd_addr      = r_rd_ptr;

      case (r_state)
         ST_IDLE, ST_READY, ST_DONE: begin
            w_ld_ready = !i_start;
            if (i_start && (r_state != ST_IDLE)) begin
               w_exec_nxt   = 1'b1;
               w_rd_en      = 1'b1;
               w_rd_addr    = '0;
               w_rd_ptr_nxt = AW'(1);
               w_state_nxt  = ST_RUN;
            end else if (i_ld_valid && w_ld_ready) begin
               w_wr_en   = 1'b1;
               w_wr_addr = '0;
            end
         end
         ST_LOAD: begin
            w_ld_ready = !i_start;
            if (i_ld_valid && w_ld_ready) begin
               w_wr_en = 1'b1;
            end
         end
         ST_RUN: begin
`ifdef INSTR_FEEDER_LOOP_EN
            if (i_start) begin
               w_exec_nxt  = 1'b1;
               w_state_nxt = ST_STOP;
            end else if (w_phase_last) begin
               w_rd_en = 1'b1;
               if (w_last_word) begin
                  w_rd_addr    = '0;
                  w_rd_ptr_nxt = AW'(1);
               end else begin
                  w_rd_ptr_nxt = r_rd_ptr + AW'(1);
               end
            end
`else
            if (w_phase_last) begin
               if (w_last_word) begin
                  w_exec_nxt  = 1'b1;
                  w_rd_clr    = 1'b1;
                  w_state_nxt = ST_STOP;
               end else begin
                  w_rd_en      = 1'b1;
                  w_rd_ptr_nxt = r_rd_ptr + AW'(1);
               end
            end
`endif
         end
         ST_STOP: begin
            if (w_phase_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Common handling of an accepted load word.
      if (w_wr_en) begin
         w_wr_ptr_nxt = w_wr_addr + AW'(1);
         if (w_ld_word.last || (w_wr_addr == AW'(DEPTH - 1))) begin
            w_prog_len_nxt = (AW+1)'(w_wr_addr) + (AW+1)'(1);
            w_state_nxt    = ST_READY;
         end else begin
            w_prog_len_nxt = '0;
            w_state_nxt    = ST_LOAD;
         end
      end
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_prog_len <= '0;
         r_exec     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_prog_len <= w_prog_len_nxt;
         r_exec     <= w_exec_nxt;
         r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STOP);
         r_done     <= (w_state_nxt == ST_DONE);
      end
   end

   instr_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_ld_word.data),
      .i_rd_en   (w_rd_en),
      .i_rd_clr  (w_rd_clr),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (o_meirei)
   );

   assign o_ld_ready = w_ld_ready;
   assign o_exec     = r_exec;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_prog_len = r_prog_len;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder (DEPTH=4, default build).
module tb_instr_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [15:0] ld_data = '0;
   logic        ld_last = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  phase = '0;
   logic [15:0] meirei;
   logic        exec_o;
   logic        busy;
   logic        done;
   logic [2:0]  prog_len;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   instr_feeder #(.DEPTH(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_ld_valid (ld_valid),
      .o_ld_ready (ld_ready),
      .i_ld_data  (ld_data),
      .i_ld_last  (ld_last),
      .i_start    (start),
      .i_phase    (phase),
      .o_meirei   (meirei),
      .o_exec     (exec_o),
      .o_busy     (busy),
      .o_done     (done),
      .o_prog_len (prog_len)
   );

   typedef struct {
      logic        rst, ldv;
      logic [15:0] ldd;
      logic        ldl, st;
      logic [2:0]  ph;
      logic        rdy;
      logic [15:0] m;
      logic        ex, bsy, dn;
      logic [2:0]  pl;
   } vec_t;

   vec_t tbl [27];

   function automatic vec_t mkv(logic r, logic v, logic [15:0] d, logic l, logic s,
                                logic [2:0] ph, logic rdy, logic [15:0] m,
                                logic ex, logic bsy, logic dn, logic [2:0] pl);
      vec_t t;
      t.rst = r; t.ldv = v; t.ldd = d; t.ldl = l; t.st = s; t.ph = ph;
      t.rdy = rdy; t.m = m; t.ex = ex; t.bsy = bsy; t.dn = dn; t.pl = pl;
      return t;
   endfunction

   // Drive inputs mid-cycle, away from the active edge.
   task automatic drv(input logic r, input logic v, input logic [15:0] d, input logic l,
                      input logic s, input logic [2:0] ph);
      @(negedge clk);
      rst = r; ld_valid = v; ld_data = d; ld_last = l; start = s; phase = ph;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ck_rdy(input string nm, input logic exp);
      n_total++;
      if (ld_ready === exp) n_pass++;
      else $display("FAIL %s: ld_ready got %b want %b", nm, ld_ready, exp);
   endtask

   task automatic ck_out(input string nm, input logic [15:0] m, input logic ex,
                         input logic bsy, input logic dn, input logic [2:0] pl);
      n_total++;
      if ({meirei, exec_o, busy, done, prog_len} === {m, ex, bsy, dn, pl}) n_pass++;
      else $display("FAIL %s: got meirei=%h exec=%b busy=%b done=%b len=%0d want meirei=%h exec=%b busy=%b done=%b len=%0d",
                    nm, meirei, exec_o, busy, done, prog_len, m, ex, bsy, dn, pl);
   endtask

   task automatic apply(input int i);
      drv(tbl[i].rst, tbl[i].ldv, tbl[i].ldd, tbl[i].ldl, tbl[i].st, tbl[i].ph);
      ck_rdy($sformatf("vec%0d", i), tbl[i].rdy);
      tick();
      ck_out($sformatf("vec%0d", i), tbl[i].m, tbl[i].ex, tbl[i].bsy, tbl[i].dn, tbl[i].pl);
   endtask

   // Phases 1..4 without checks, leaving phase 5 to the caller.
   task automatic pre_phases();
      for (int k = 1; k <= 4; k++) begin
         drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'(k));
         tick();
      end
   endtask

   task automatic load(input logic [15:0] d, input logic l);
      drv(1'b0, 1'b1, d, l, 1'b0, 3'd0);
      tick();
   endtask

   initial begin
      // Basic run: load 3 words, start, walk the core phases.
      tbl[0] = mkv(1, 0, 16'h0000, 0, 0, 3'd0, 1, 16'h0000, 0, 0, 0, 3'd0);
      tbl[1] = mkv(0, 1, 16'h1111, 0, 0, 3'd0, 1, 16'h0000, 0, 0, 0, 3'd0);
      tbl[2] = mkv(0, 1, 16'h2222, 0, 0, 3'd0, 1, 16'h0000, 0, 0, 0, 3'd0);
      tbl[3] = mkv(0, 1, 16'h3333, 1, 0, 3'd0, 1, 16'h0000, 0, 0, 0, 3'd3);
      tbl[4] = mkv(0, 0, 16'h0000, 0, 0, 3'd0, 1, 16'h0000, 0, 0, 0, 3'd3);
      tbl[5] = mkv(0, 0, 16'h0000, 0, 1, 3'd0, 0, 16'h1111, 1, 1, 0, 3'd3);
      for (int k = 1; k <= 4; k++)
         tbl[5+k]  = mkv(0, 0, 16'h0, 0, 0, 3'(k), 0, 16'h1111, 0, 1, 0, 3'd3);
      tbl[10] = mkv(0, 0, 16'h0000, 0, 0, 3'd5, 0, 16'h2222, 0, 1, 0, 3'd3);
      for (int k = 1; k <= 4; k++)
         tbl[10+k] = mkv(0, 0, 16'h0, 0, 0, 3'(k), 0, 16'h2222, 0, 1, 0, 3'd3);
      tbl[15] = mkv(0, 0, 16'h0000, 0, 0, 3'd5, 0, 16'h3333, 0, 1, 0, 3'd3);
      for (int k = 1; k <= 4; k++)
         tbl[15+k] = mkv(0, 0, 16'h0, 0, 0, 3'(k), 0, 16'h3333, 0, 1, 0, 3'd3);
      tbl[20] = mkv(0, 0, 16'h0000, 0, 0, 3'd5, 0, 16'h0000, 1, 1, 0, 3'd3);
      for (int k = 1; k <= 4; k++)
         tbl[20+k] = mkv(0, 0, 16'h0, 0, 0, 3'(k), 0, 16'h0000, 0, 1, 0, 3'd3);
      tbl[25] = mkv(0, 0, 16'h0000, 0, 0, 3'd5, 0, 16'h0000, 0, 0, 1, 3'd3);
      tbl[26] = mkv(0, 0, 16'h0000, 0, 0, 3'd0, 1, 16'h0000, 0, 0, 1, 3'd3);

      tick();
      tick();

      for (int i = 0; i < 27; i++) apply(i);
      // Rerun from DONE without reloading.
      for (int i = 5; i < 27; i++) apply(i);

      // Full buffer: four words with ld_last=0 end the load at DEPTH.
      load(16'hA000, 1'b0); ck_out("full_w0", 16'h0, 0, 0, 0, 3'd0);
      load(16'hA001, 1'b0);
      load(16'hA002, 1'b0); ck_out("full_w2", 16'h0, 0, 0, 0, 3'd0);
      load(16'hA003, 1'b0); ck_out("full_w3", 16'h0, 0, 0, 0, 3'd4);
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      ck_rdy("full_ready", 1'b1);
      // Run the full program: the read pointer wraps on the last word.
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0); tick();
      ck_out("full_start", 16'hA000, 1, 1, 0, 3'd4);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("full_h1", 16'hA001, 0, 1, 0, 3'd4);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("full_h2", 16'hA002, 0, 1, 0, 3'd4);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("full_h3", 16'hA003, 0, 1, 0, 3'd4);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("full_stop", 16'h0000, 1, 1, 0, 3'd4);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("full_done", 16'h0000, 0, 0, 1, 3'd4);

      // Reload from DONE restarts at address 0.
      load(16'hB000, 1'b0); ck_out("reload_w0", 16'h0, 0, 0, 0, 3'd0);
      load(16'hB001, 1'b1); ck_out("reload_w1", 16'h0, 0, 0, 0, 3'd2);

      // Start and load together in READY: start wins, nothing is written.
      drv(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 3'd0);
      ck_rdy("collide_rdy", 1'b0);
      tick();
      ck_out("collide_start", 16'hB000, 1, 1, 0, 3'd2);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("collide_h1", 16'hB001, 0, 1, 0, 3'd2);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("collide_stop", 16'h0000, 1, 1, 0, 3'd2);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("collide_done", 16'h0000, 0, 0, 1, 3'd2);

      // Reset mid-run at phase 3; load blocked while running.
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0); tick();
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd1); tick();
      drv(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 3'd2);
      ck_rdy("run_blocks_load", 1'b0);
      tick();
      drv(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd3); tick();
      ck_out("midrun_reset", 16'h0000, 0, 0, 0, 3'd0);
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
      ck_rdy("reset_rdy", 1'b1);

      // Start in IDLE is ignored.
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0);
      ck_rdy("idle_start_rdy", 1'b0);
      tick();
      ck_out("idle_start", 16'h0000, 0, 0, 0, 3'd0);

      // Single-word program: stop pulse at the first phase 5 edge.
      load(16'h5A5A, 1'b1); ck_out("single_load", 16'h0, 0, 0, 0, 3'd1);
      drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0); tick();
      ck_out("single_start", 16'h5A5A, 1, 1, 0, 3'd1);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("single_stop", 16'h0000, 1, 1, 0, 3'd1);
      pre_phases(); drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd5); tick();
      ck_out("single_done", 16'h0000, 0, 0, 1, 3'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Host-side instruction source for the 16-bit phase-sequenced core: the writer end of the core's `meirei`/`exec` instruction interface. A host loads a program word-by-word into an internal buffer. On `start` the block pulses `exec` to launch the core, presents each instruction on `meirei` in step with the core's `phase` output, and pulses `exec` again after the last word so the core halts cleanly. It sits beside the core at top level and shares its clock and reset.

## Interface
- `DEPTH`, 64: instruction buffer entries; power of two, at least 2.
- `AW`, $clog2(DEPTH): buffer address width; derived, not overridden.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ld_valid`  in  1: host offers `ld_data`.
- `ld_ready`  out  1: a word is accepted on a cycle where `ld_valid & ld_ready`.
- `ld_data`  in  16: instruction word.
- `ld_last`  in  1: the accepted word is the final program word.
- `start`  in  1: single-cycle run request.
- `phase`  in  3: core phase counter; 0 = idle, 1–5 = execution phases.
- `meirei`  out  16: registered instruction word to the core.
- `exec`  out  1: registered single-cycle start/stop pulse to the core.
- `busy`  out  1: high in RUN and STOP.
- `done`  out  1: high in DONE.
- `prog_len`  out  AW+1: number of words in the loaded program.

## Operation
- **States:** IDLE, LOAD, READY, RUN, STOP, DONE.
- **Load acceptance:** `ld_ready = (state ∈ {IDLE, LOAD, READY, DONE}) & !start`.
  - An accepted word in IDLE, READY or DONE restarts loading: it is written at address 0, `wr_ptr` becomes 1, state becomes LOAD, and `prog_len` clears to 0.
  - In LOAD, an accepted word is written at `wr_ptr`, then `wr_ptr` increments.
- **End of load:**
  - An accepted `ld_last` sets `prog_len = wr_ptr+1` and moves to READY.
  - If the word written at address DEPTH-1 has `ld_last=0`, it is forced last: `prog_len = DEPTH` and state moves to READY.
- **Start:** `start` in READY or DONE causes, at the same edge:
  - `exec` set to 1;
  - `rd_ptr` set to 1;
  - `meirei` loaded with `buf[0]`;
  - state set to RUN.
  
  `start` in IDLE, LOAD or STOP is ignored.
- **RUN:**
  - On each edge where `phase==5`, the core latches `meirei`.
  - At that same edge, the feeder loads `meirei <= buf[rd_ptr]` and increments `rd_ptr`.
  - When the handed-over word is word `prog_len-1`, the feeder sets `exec` to 1 (stop request) at that edge and moves to STOP. In that case `meirei` loads 0x0000 instead of the next buffer word.
- **STOP:** wait for an edge with `phase==5` (the core finishing the last word), then go to DONE.
- **DONE:** `done=1`. The program stays intact and can be rerun with `start` or replaced by loading.
- **Buffer:** read/write pointers wrap modulo DEPTH. Reads and writes never overlap, because loading is blocked in RUN and STOP.

## Timing
- **Reset values:** state IDLE; `meirei=0x0000`; `exec=0`; `ld_ready=1`; `busy=0`; `done=0`; `prog_len=0`; pointers 0.
- **Reset mid-operation:** the same values apply at the next edge, and buffer contents are don't-care.
- **`exec` pulse width:** exactly one cycle. Two pulses are at least 5 cycles apart.
- **`meirei` validity:**
  - First word is valid from the cycle after the `start` edge.
  - Each subsequent word is valid from the cycle after each `phase==5` edge.
  - Read latency from the buffer is one cycle (synchronous-read RAM).
- **Single-word program:** the stop `exec` pulse is issued at the first `phase==5` edge in RUN.
- **Simultaneous `start` and `ld_valid`:** `start` wins, because `ld_ready` is 0 that cycle.
- **`ld_valid` with `ld_ready=0`:** no write, no state change; the host must hold the word.

## Configuration
- **`INSTR_FEEDER_LOOP_EN` defined:**
  - After word `prog_len-1` is handed over, `rd_ptr` wraps to 0 and RUN continues; no stop pulse is issued.
  - `start` in RUN sets `exec` to 1 and moves to STOP.
- **`INSTR_FEEDER_LOOP_EN` undefined:**
  - Behaviour is exactly as described above.
  - `start` in RUN is ignored.

## Structure
- **Package `instr_feeder_pkg`:**
  - state enum `feeder_state_t`;
  - `WORD_W=16`;
  - `PHASE_IDLE=3'd0`;
  - `PHASE_LAST=3'd5`.
- **Sub-module `instr_buf`:** simple dual-port RAM, DEPTH×16, with synchronous write and synchronous read.

## Test plan
- **Basic run:** load 3 words 0x1111, 0x2222, 0x3333 (last on third), pulse `start`, then drive `phase` 0→1…5 repeatedly.
  - Expect `exec` pulse one cycle after `start`.
  - Expect `meirei` to show 0x1111, then 0x2222, then 0x3333 after successive `phase==5` edges.
  - Expect a second `exec` pulse one cycle after the third `phase==5` edge, and `done=1` after the fourth.
- **Full buffer:** with DEPTH=4, load 4 words with `ld_last=0`.
  - Expect `prog_len=4` and state READY.
  - Expect a fifth word offered immediately to restart loading at address 0 with `prog_len=0`.
- **Start/load collision:** assert `start` and `ld_valid` together in READY.
  - Expect `ld_ready=0`, no write, `exec=1` next cycle, and `busy=1`.
- **Reset mid-run:** assert `rst` during RUN at `phase==3`.
  - Expect `meirei=0x0000`, `exec=0`, `busy=0`, `done=0`, `prog_len=0` after one edge.
- **Rerun from DONE:** after DONE, pulse `start`.
  - Expect an identical sequence with no reload.
- **Loop mode:** with `INSTR_FEEDER_LOOP_EN`, load 2 words and run 3 handovers.
  - Expect word 0, word 1, word 0 with no stop pulse.
  - Then `start` produces an `exec` pulse and STOP, followed by DONE after the next `phase==5`.
